// File: rtl/mem_stage_if.sv
// Data-bus port bundle between the memory stage and the data memory/cache.
// The memory stage is the master: it drives requests and receives responses.
interface mem_stage_if;
   logic        dreq_valid;
   logic [31:0] dreq_addr;
   logic [1:0]  dreq_size;
   logic [3:0]  dreq_strobe;
   logic [31:0] dreq_data;
   logic        dresp_data_ok;
   logic [31:0] dresp_data;

   modport master (
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_data_ok, dresp_data
   );

   modport slave (
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_data_ok, dresp_data
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM pipeline register, data-bus request generation,
// a two-state handshake tracker and load alignment/extension for writeback.
module mem_stage (
   input  logic        clk,
   input  logic        resetn,
   input  logic        StallM,
   input  logic        FlushM,
   input  logic [31:0] ALUOutE,
   input  logic [31:0] WriteDataE,
   input  logic [4:0]  WriteRegE,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   input  logic [1:0]  SizeE,
   input  logic        SignedE,
   output logic [31:0] ALUOutM,
   output logic [4:0]  WriteRegM,
   output logic        RegWriteM,
   output logic        MemtoRegM,
   output logic [31:0] ReadDataM,
   output logic        BusyM,
   output logic        MisalignM,
   mem_stage_if.master dbus
);

   localparam logic [0:0] ISSUE = 1'b0;
   localparam logic [0:0] HOLD  = 1'b1;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;

   logic [31:0] writeDataM;
   logic        regWriteRaw;
   logic        memWriteM;
   logic [1:0]  sizeM;
   logic        signedM;

   logic [0:0]  state;
   logic [31:0] holdBuf;

   logic        memOp;
   logic        misaligned;
   logic        reqValid;
   logic        advance;
   logic [31:0] rawData;
   logic [31:0] shifted;
   logic [4:0]  shiftAmt;
   logic [31:0] loadExt;
   logic [3:0]  strobe;
   logic [31:0] storeData;

   // Flush beats stall so a killed instruction never lingers in the register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ALUOutM     <= '0;
         writeDataM  <= '0;
         WriteRegM   <= '0;
         regWriteRaw <= 1'b0;
         MemtoRegM   <= 1'b0;
         memWriteM   <= 1'b0;
         sizeM       <= '0;
         signedM     <= 1'b0;
      end else if (FlushM) begin
         ALUOutM     <= '0;
         writeDataM  <= '0;
         WriteRegM   <= '0;
         regWriteRaw <= 1'b0;
         MemtoRegM   <= 1'b0;
         memWriteM   <= 1'b0;
         sizeM       <= '0;
         signedM     <= 1'b0;
      end else if (!StallM) begin
         ALUOutM     <= ALUOutE;
         writeDataM  <= WriteDataE;
         WriteRegM   <= WriteRegE;
         regWriteRaw <= RegWriteE;
         MemtoRegM   <= MemtoRegE;
         memWriteM   <= MemWriteE;
         sizeM       <= SizeE;
         signedM     <= SignedE;
      end
   end

   assign memOp      = MemtoRegM | memWriteM;
   assign misaligned = ((sizeM == SIZE_HALF) & ALUOutM[0]) |
                       ((sizeM != SIZE_BYTE) & (sizeM != SIZE_HALF) & (ALUOutM[1:0] != 2'b00));
   assign MisalignM  = memOp & misaligned;
   assign RegWriteM  = regWriteRaw & ~MisalignM;
   assign reqValid   = (state == ISSUE) & memOp & ~MisalignM;
   assign BusyM      = reqValid & ~dbus.dresp_data_ok;
   assign advance    = FlushM | ~StallM;

   // A response that arrives while the pipe is frozen is parked in holdBuf
   // so the bus is free to move on before the register advances.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ISSUE;
         holdBuf <= '0;
      end else begin
         case (state)
            ISSUE: begin
               if (reqValid & dbus.dresp_data_ok & ~advance) begin
                  state   <= HOLD;
                  holdBuf <= dbus.dresp_data;
               end
            end
            default: begin
               if (advance) state <= ISSUE;
            end
         endcase
      end
   end

   always_comb begin
      strobe    = 4'b0000;
      storeData = writeDataM;
      case (sizeM)
         SIZE_BYTE: begin
            strobe    = 4'b0001 << ALUOutM[1:0];
            storeData = {4{writeDataM[7:0]}};
         end
         SIZE_HALF: begin
            strobe    = 4'b0011 << ALUOutM[1:0];
            storeData = {2{writeDataM[15:0]}};
         end
         default: strobe = 4'b1111;
      endcase
      if (!memWriteM) strobe = 4'b0000;
   end

   assign dbus.dreq_valid  = reqValid;
   assign dbus.dreq_addr   = ALUOutM;
   assign dbus.dreq_size   = sizeM;
   assign dbus.dreq_strobe = strobe;
   assign dbus.dreq_data   = storeData;

   assign rawData  = (state == HOLD) ? holdBuf : dbus.dresp_data;
   assign shiftAmt = {ALUOutM[1:0], 3'b000};
   assign shifted  = rawData >> shiftAmt;

   always_comb begin
      loadExt = shifted;
      case (sizeM)
         SIZE_BYTE: loadExt = {{24{signedM & shifted[7]}}, shifted[7:0]};
         SIZE_HALF: loadExt = {{16{signedM & shifted[15]}}, shifted[15:0]};
         default:   loadExt = shifted;
      endcase
   end

   assign ReadDataM = MemtoRegM ? loadExt : 32'h0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, stall/hold, misalignment,
// flush and asynchronous reset, each checked against hand-computed values.
module tb_mem_stage;

   logic        clk;
   logic        resetn;
   logic        StallM;
   logic        FlushM;
   logic [31:0] ALUOutE;
   logic [31:0] WriteDataE;
   logic [4:0]  WriteRegE;
   logic        RegWriteE;
   logic        MemtoRegE;
   logic        MemWriteE;
   logic [1:0]  SizeE;
   logic        SignedE;
   logic [31:0] ALUOutM;
   logic [4:0]  WriteRegM;
   logic        RegWriteM;
   logic        MemtoRegM;
   logic [31:0] ReadDataM;
   logic        BusyM;
   logic        MisalignM;

   int passCount  = 0;
   int checkCount = 0;

   mem_stage_if bus ();

   mem_stage dut (
      .clk        (clk),
      .resetn     (resetn),
      .StallM     (StallM),
      .FlushM     (FlushM),
      .ALUOutE    (ALUOutE),
      .WriteDataE (WriteDataE),
      .WriteRegE  (WriteRegE),
      .RegWriteE  (RegWriteE),
      .MemtoRegE  (MemtoRegE),
      .MemWriteE  (MemWriteE),
      .SizeE      (SizeE),
      .SignedE    (SignedE),
      .ALUOutM    (ALUOutM),
      .WriteRegM  (WriteRegM),
      .RegWriteM  (RegWriteM),
      .MemtoRegM  (MemtoRegM),
      .ReadDataM  (ReadDataM),
      .BusyM      (BusyM),
      .MisalignM  (MisalignM),
      .dbus       (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount = checkCount + 1;
      assert (obs === exp) passCount = passCount + 1;
      else $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // Present one instruction on the E inputs, clock it in, then leave a bubble behind it.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wreg,
                                input logic rw, input logic m2r, input logic mw,
                                input logic [1:0] size, input logic sgn);
      ALUOutE    = addr;
      WriteDataE = wd;
      WriteRegE  = wreg;
      RegWriteE  = rw;
      MemtoRegE  = m2r;
      MemWriteE  = mw;
      SizeE      = size;
      SignedE    = sgn;
      tick();
      ALUOutE    = '0;
      WriteDataE = '0;
      WriteRegE  = '0;
      RegWriteE  = 1'b0;
      MemtoRegE  = 1'b0;
      MemWriteE  = 1'b0;
      SizeE      = '0;
      SignedE    = 1'b0;
      #1;
   endtask

   initial begin
      resetn = 1'b0;
      StallM = 1'b0;
      FlushM = 1'b0;
      ALUOutE = '0; WriteDataE = '0; WriteRegE = '0;
      RegWriteE = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0;
      SizeE = '0; SignedE = 1'b0;
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data    = '0;

      #12;
      checkOutput("resetAluOut",   ALUOutM, 32'h0);
      checkOutput("resetValid",    {31'h0, bus.dreq_valid}, 32'h0);
      checkOutput("resetBusy",     {31'h0, BusyM}, 32'h0);
      checkOutput("resetReadData", ReadDataM, 32'h0);
      checkOutput("resetRegWrite", {31'h0, RegWriteM}, 32'h0);
      resetn = 1'b1;

      // Word load with zero-wait response
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = 32'hDEADBEEF;
      applyStimulus(32'h1000, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      checkOutput("lwValid",    {31'h0, bus.dreq_valid}, 32'h1);
      checkOutput("lwBusy",     {31'h0, BusyM}, 32'h0);
      checkOutput("lwData",     ReadDataM, 32'hDEADBEEF);
      checkOutput("lwAddr",     bus.dreq_addr, 32'h1000);
      checkOutput("lwWriteReg", {27'h0, WriteRegM}, 32'd5);
      checkOutput("lwRegWrite", {31'h0, RegWriteM}, 32'h1);

      // Signed then unsigned byte load from the top lane
      bus.dresp_data = 32'h80FF0000;
      applyStimulus(32'h1003, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
      checkOutput("lbSigned", ReadDataM, 32'hFFFFFF80);
      applyStimulus(32'h1003, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
      checkOutput("lbUnsigned", ReadDataM, 32'h00000080);

      // Signed half load from the upper half
      bus.dresp_data = 32'h80010000;
      applyStimulus(32'h1002, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);
      checkOutput("lhSigned", ReadDataM, 32'hFFFF8001);

      // Byte store, zero-wait
      applyStimulus(32'h2001, 32'h0000005A, 5'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      checkOutput("sbStrobe",   {28'h0, bus.dreq_strobe}, 32'h2);
      checkOutput("sbData",     bus.dreq_data, 32'h5A5A5A5A);
      checkOutput("sbReadData", ReadDataM, 32'h0);

      // Half store with three wait cycles
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data    = '0;
      applyStimulus(32'h2002, 32'h0000ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
      checkOutput("shStrobe", {28'h0, bus.dreq_strobe}, 32'hC);
      checkOutput("shData",   bus.dreq_data, 32'hABCDABCD);
      checkOutput("shSize",   {30'h0, bus.dreq_size}, 32'h1);
      StallM = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("shBusyWait", {31'h0, BusyM}, 32'h1);
         tick();
      end
      checkOutput("shStrobeHeld", {28'h0, bus.dreq_strobe}, 32'hC);
      bus.dresp_data_ok = 1'b1;
      StallM = 1'b0;
      #1;
      checkOutput("shBusyDone", {31'h0, BusyM}, 32'h0);
      tick();
      bus.dresp_data_ok = 1'b0;
      #1;
      checkOutput("shValidAfter", {31'h0, bus.dreq_valid}, 32'h0);

      // Load completes while stalled; later bus data must not leak through
      applyStimulus(32'h3000, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      checkOutput("holdBusyPre", {31'h0, BusyM}, 32'h1);
      StallM = 1'b1;
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = 32'h12345678;
      #1;
      checkOutput("holdBusyOk", {31'h0, BusyM}, 32'h0);
      checkOutput("holdDataOk", ReadDataM, 32'h12345678);
      tick();
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data    = 32'hCAFEF00D;
      #1;
      checkOutput("holdValid1", {31'h0, bus.dreq_valid}, 32'h0);
      checkOutput("holdData1",  ReadDataM, 32'h12345678);
      tick();
      checkOutput("holdData2",  ReadDataM, 32'h12345678);
      checkOutput("holdBusy2",  {31'h0, BusyM}, 32'h0);
      StallM = 1'b0;
      tick();
      checkOutput("holdReleased", ReadDataM, 32'h0);

      // Misaligned word load is suppressed
      applyStimulus(32'h1002, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      checkOutput("misMisalign", {31'h0, MisalignM}, 32'h1);
      checkOutput("misValid",    {31'h0, bus.dreq_valid}, 32'h0);
      checkOutput("misBusy",     {31'h0, BusyM}, 32'h0);
      checkOutput("misRegWrite", {31'h0, RegWriteM}, 32'h0);

      // Flush together with stall during an outstanding request
      applyStimulus(32'h4000, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      checkOutput("flushBusyPre", {31'h0, BusyM}, 32'h1);
      StallM = 1'b1;
      FlushM = 1'b1;
      tick();
      checkOutput("flushValid",    {31'h0, bus.dreq_valid}, 32'h0);
      checkOutput("flushAluOut",   ALUOutM, 32'h0);
      checkOutput("flushRegWrite", {31'h0, RegWriteM}, 32'h0);
      checkOutput("flushBusy",     {31'h0, BusyM}, 32'h0);
      StallM = 1'b0;
      FlushM = 1'b0;

      // Word store followed by a stalled load parked in HOLD, then async reset
      applyStimulus(32'h5000, 32'h00000011, 5'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
      checkOutput("swStrobe", {28'h0, bus.dreq_strobe}, 32'hF);
      checkOutput("swData",   bus.dreq_data, 32'h00000011);
      bus.dresp_data_ok = 1'b1;
      applyStimulus(32'h5004, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      StallM = 1'b1;
      bus.dresp_data = 32'h00000077;
      tick();
      bus.dresp_data_ok = 1'b0;
      #1;
      checkOutput("rstPreHold", {31'h0, bus.dreq_valid}, 32'h0);
      resetn = 1'b0;
      #1;
      checkOutput("rstAluOut",   ALUOutM, 32'h0);
      checkOutput("rstWriteReg", {27'h0, WriteRegM}, 32'h0);
      checkOutput("rstReadData", ReadDataM, 32'h0);
      checkOutput("rstStrobe",   {28'h0, bus.dreq_strobe}, 32'h0);
      checkOutput("rstBusy",     {31'h0, BusyM}, 32'h0);
      resetn = 1'b1;
      StallM = 1'b0;

      // FSM must be back in ISSUE: a new load issues immediately
      bus.dresp_data = 32'h0BADF00D;
      applyStimulus(32'h6000, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0);
      checkOutput("postRstValid", {31'h0, bus.dreq_valid}, 32'h1);
      checkOutput("postRstBusy",  {31'h0, BusyM}, 32'h1);
      bus.dresp_data_ok = 1'b1;
      #1;
      checkOutput("postRstData",  ReadDataM, 32'h0BADF00D);
      tick();
      bus.dresp_data_ok = 1'b0;

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
